// File: rtl/masc_seq_pkg.sv
// Shared constants for the MASC execute sequencer: register map, STATUS layout
// and the FSM state type.
package masc_seq_pkg;

  localparam logic [2:0] ADDR_INSN   = 3'd0;
  localparam logic [2:0] ADDR_RS1    = 3'd1;
  localparam logic [2:0] ADDR_RS2    = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_RES_LO = 3'd5;
  localparam logic [2:0] ADDR_RES_HI = 3'd6;

  localparam int ST_BUSY          = 0;
  localparam int ST_EMPTY         = 1;
  localparam int ST_FULL          = 2;
  localparam int ST_COUNT_LSB     = 4;
  localparam int ST_ISSUE_ERR     = 8;
  localparam int ST_UNDERFLOW_ERR = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  // Byte-lane merge of a Wishbone write into an existing 32-bit register.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/masc_result_fifo.sv
// Circular result FIFO with wrapping pointers and a separate occupancy count.
// A pop and a push in the same cycle both take effect, even when full.
module masc_result_fifo #(
  parameter  int unsigned WIDTH = 33,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // NOTE: storage is not reset; pointers and count define validity, so a
  // reset that zeroes them discards contents without clearing the array.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/masc_exec_sequencer.sv
// Wishbone front end for the MASC execute unit: holds operands for EXEC_LAT
// cycles after GO, then captures the 33-bit result into a poppable FIFO.
module masc_exec_sequencer
  import masc_seq_pkg::*;
#(
  parameter int unsigned EXEC_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] exec_instruction,
  output logic [31:0] exec_rs1,
  output logic [31:0] exec_rs2,
  input  logic [32:0] exec_out,
  output logic        irq_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e        r_state, w_state_next;
  logic [3:0]    r_cnt, w_cnt_next;
  logic          r_ack, r_irq, r_issue_err, r_underflow_err;
  logic [31:0]   r_dat, r_insn, r_rs1, r_rs2;
  logic [31:0]   w_status, w_rdata;
  logic [32:0]   w_fifo_data, w_head;
  logic [CW-1:0] w_count;
  logic [2:0]    w_adr;
  logic w_access, w_wr, w_rd, w_idle, w_op_wr, w_go_req, w_go, w_issue_err_set;
  logic w_pop, w_push, w_full, w_empty, w_status_wr;
  logic w_unused_adr;

  assign w_adr        = wbs_adr_i[4:2];
  assign w_unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};
  // Accesses take effect only on the edge that raises ack, never on the next.
  assign w_access     = wbs_cyc_i && wbs_stb_i && !r_ack;
  assign w_wr         = w_access && wbs_we_i;
  assign w_rd         = w_access && !wbs_we_i;
  assign w_idle       = (r_state == S_IDLE);

  assign w_op_wr  = w_wr && (w_adr == ADDR_INSN || w_adr == ADDR_RS1 || w_adr == ADDR_RS2);
  assign w_go_req = w_wr && (w_adr == ADDR_CTRL) && wbs_dat_i[0];
  assign w_go     = w_go_req && w_idle;
  assign w_issue_err_set = (w_op_wr || w_go_req) && !w_idle;
  assign w_status_wr     = w_wr && (w_adr == ADDR_STATUS);

  assign w_pop  = w_rd && (w_adr == ADDR_RES_LO);
  // A pop on the same edge frees the slot a stalled capture is waiting for.
  assign w_push = (r_state == S_CAPTURE) && (!w_full || (w_pop && !w_empty));
  assign w_head = w_empty ? '0 : w_fifo_data;

  masc_result_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (exec_out),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_next = S_DRIVE;
          w_cnt_next   = 4'(EXEC_LAT);
        end
      end
      S_DRIVE: begin
        if (r_cnt == 4'd0) w_state_next = S_CAPTURE;
        else               w_cnt_next   = r_cnt - 4'd1;
      end
      S_CAPTURE: begin
        if (w_push) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_status                          = '0;
    w_status[ST_BUSY]                 = !w_idle;
    w_status[ST_EMPTY]                = w_empty;
    w_status[ST_FULL]                 = w_full;
    w_status[ST_COUNT_LSB +: CW]      = w_count;
    w_status[ST_ISSUE_ERR]            = r_issue_err;
    w_status[ST_UNDERFLOW_ERR]        = r_underflow_err;
  end

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      ADDR_INSN:   w_rdata = r_insn;
      ADDR_RS1:    w_rdata = r_rs1;
      ADDR_RS2:    w_rdata = r_rs2;
      ADDR_STATUS: w_rdata = w_status;
      ADDR_RES_LO: w_rdata = w_head[31:0];
      ADDR_RES_HI: w_rdata = {31'd0, w_head[32]};
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_ack           <= 1'b0;
      r_dat           <= '0;
      r_insn          <= '0;
      r_rs1           <= '0;
      r_rs2           <= '0;
      r_issue_err     <= 1'b0;
      r_underflow_err <= 1'b0;
      r_irq           <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= w_access;
      r_dat   <= w_rd ? w_rdata : '0;
      r_irq   <= (w_count != '0);

      if (w_op_wr && w_idle) begin
        case (w_adr)
          ADDR_INSN: r_insn <= apply_sel(r_insn, wbs_dat_i, wbs_sel_i);
          ADDR_RS1:  r_rs1  <= apply_sel(r_rs1,  wbs_dat_i, wbs_sel_i);
          default:   r_rs2  <= apply_sel(r_rs2,  wbs_dat_i, wbs_sel_i);
        endcase
      end

      if (w_issue_err_set)                       r_issue_err <= 1'b1;
      else if (w_status_wr && wbs_dat_i[ST_ISSUE_ERR]) r_issue_err <= 1'b0;

      if (w_pop && w_empty)                      r_underflow_err <= 1'b1;
      else if (w_status_wr && wbs_dat_i[ST_UNDERFLOW_ERR]) r_underflow_err <= 1'b0;
    end
  end

  assign wbs_ack_o        = r_ack;
  assign wbs_dat_o        = r_dat;
  assign exec_instruction = r_insn;
  assign exec_rs1         = r_rs1;
  assign exec_rs2         = r_rs2;
  assign irq_o            = r_irq;

endmodule

// File: tb/tb_masc_exec_sequencer.sv
// Bench for masc_exec_sequencer: directed scenarios plus random Wishbone traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_masc_exec_sequencer;

  localparam int EXEC_LAT   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam logic [2:0] A_INSN = 3'd0, A_RS1 = 3'd1, A_RS2 = 3'd2, A_CTRL = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4, A_RES_LO = 3'd5, A_RES_HI = 3'd6;

  logic        wb_clk_i, wb_rst_ni;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] exec_instruction, exec_rs1, exec_rs2;
  logic [32:0] exec_out;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  masc_exec_sequencer #(
    .EXEC_LAT   (EXEC_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .wb_clk_i         (wb_clk_i),
    .wb_rst_ni        (wb_rst_ni),
    .wbs_cyc_i        (wbs_cyc_i),
    .wbs_stb_i        (wbs_stb_i),
    .wbs_we_i         (wbs_we_i),
    .wbs_sel_i        (wbs_sel_i),
    .wbs_adr_i        (wbs_adr_i),
    .wbs_dat_i        (wbs_dat_i),
    .wbs_ack_o        (wbs_ack_o),
    .wbs_dat_o        (wbs_dat_o),
    .exec_instruction (exec_instruction),
    .exec_rs1         (exec_rs1),
    .exec_rs2         (exec_rs2),
    .exec_out         (exec_out),
    .irq_o            (irq_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Execute unit stand-in: out = {carry, rs1 + rs2}, EXEC_LAT cycles behind.
  logic [32:0] pipe [EXEC_LAT];
  always @(posedge wb_clk_i) begin
    pipe[0] <= {1'b0, exec_rs1} + {1'b0, exec_rs2};
    for (int i = 1; i < EXEC_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign exec_out = pipe[EXEC_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_insn, m_rs1, m_rs2, m_dat;
  logic        m_busy, m_ierr, m_uerr, m_ack, m_irq;
  int          m_cyc, m_push_at;
  logic [32:0] m_q [$];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_insn = '0; m_rs1 = '0; m_rs2 = '0; m_dat = '0;
    m_busy = 0; m_ierr = 0; m_uerr = 0; m_ack = 0; m_irq = 0;
    m_cyc = 0; m_push_at = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic        acc, pop, busy_pre, do_push;
    logic [2:0]  a;
    logic [31:0] rd;
    logic [32:0] head;
    int          n, e;
    m_cyc++;
    e        = m_cyc;
    n        = m_q.size();
    head     = (n > 0) ? m_q[0] : 33'd0;
    busy_pre = m_busy;
    acc      = wbs_cyc_i && wbs_stb_i && !m_ack;
    a        = wbs_adr_i[4:2];
    pop      = 0;
    rd       = '0;
    if (acc && !wbs_we_i) begin
      case (a)
        A_INSN:   rd = m_insn;
        A_RS1:    rd = m_rs1;
        A_RS2:    rd = m_rs2;
        A_STATUS: rd = {22'd0, m_uerr, m_ierr, 4'(n), 1'b0, (n == FIFO_DEPTH), (n == 0), busy_pre};
        A_RES_LO: if (n > 0) begin rd = head[31:0]; pop = 1; end else m_uerr = 1;
        A_RES_HI: rd = {31'd0, head[32]};
        default:  rd = '0;
      endcase
    end
    do_push = busy_pre && (e >= m_push_at) && ((n < FIFO_DEPTH) || pop);
    if (acc && wbs_we_i) begin
      case (a)
        A_INSN:   if (busy_pre) m_ierr = 1; else m_insn = merge(m_insn, wbs_dat_i, wbs_sel_i);
        A_RS1:    if (busy_pre) m_ierr = 1; else m_rs1  = merge(m_rs1,  wbs_dat_i, wbs_sel_i);
        A_RS2:    if (busy_pre) m_ierr = 1; else m_rs2  = merge(m_rs2,  wbs_dat_i, wbs_sel_i);
        A_CTRL:   if (wbs_dat_i[0]) begin
                    if (busy_pre) m_ierr = 1;
                    else begin m_busy = 1; m_push_at = e + EXEC_LAT + 2; end
                  end
        A_STATUS: begin
                    if (wbs_dat_i[8]) m_ierr = 0;
                    if (wbs_dat_i[9]) m_uerr = 0;
                  end
        default:  ;
      endcase
    end
    m_irq = (n != 0);
    m_ack = acc;
    m_dat = rd;
    if (pop) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back({1'b0, m_rs1} + {1'b0, m_rs2});
      m_busy = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge wb_clk_i);
      if (!wb_rst_ni) model_reset();
      else            model_step();
    end
  end

  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_ni) begin
        check("ack", wbs_ack_o, m_ack);
        check("dat_o", wbs_dat_o, m_dat);
        check("exec_instruction", exec_instruction, m_insn);
        check("exec_rs1", exec_rs1, m_rs1);
        check("exec_rs2", exec_rs2, m_rs2);
        check("irq", irq_o, m_irq);
      end
    end
  end

  // ---------------- Wishbone helpers ----------------
  task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd);
    logic [31:0] r;
    int n;
    r = $urandom();
    @(negedge wb_clk_i);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = {r[31:5], a, r[1:0]};
    wbs_dat_i = d;
    n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!wbs_ack_o && n < 6);
    check("wb_ack_seen", wbs_ack_o, 1'b1);
    rd = wbs_dat_o;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] rd);
    wb_xfer(1'b0, a, 32'h0, 4'hF, rd);
  endtask

  task automatic issue_and_wait();
    wb_write(A_CTRL, 32'h1);
    repeat (EXEC_LAT + 4) @(negedge wb_clk_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, r1, r2;
    logic [32:0] exp_q [$];
    logic [32:0] e;
    wb_rst_ni = 0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (3) @(negedge wb_clk_i);
    check("reset_ack", wbs_ack_o, 1'b0);
    check("reset_dat", wbs_dat_o, 32'h0);
    check("reset_irq", irq_o, 1'b0);
    check("reset_rs1", exec_rs1, 32'h0);
    #2 wb_rst_ni = 1;
    wb_read(A_STATUS, rd);
    check("reset_status", rd, 32'h0000_0002);

    // 1. basic issue, carry into bit 32
    wb_write(A_RS1, 32'hFFFF_FFFF);
    wb_write(A_RS2, 32'h0000_0002);
    wb_write(A_CTRL, 32'h1);
    repeat (EXEC_LAT + 2) @(negedge wb_clk_i);
    check("t1_irq_before_push", irq_o, 1'b0);
    @(negedge wb_clk_i);
    check("t1_irq_after_push", irq_o, 1'b1);
    wb_read(A_RES_HI, rd);  check("t1_res_hi", rd, 32'h1);
    wb_read(A_RES_LO, rd);  check("t1_res_lo", rd, 32'h1);
    wb_read(A_STATUS, rd);  check("t1_status", rd, 32'h0000_0002);
    check("t1_irq_clear", irq_o, 1'b0);

    // 2. busy protection
    wb_write(A_RS1, 32'h10);
    wb_write(A_RS2, 32'h20);
    wb_write(A_CTRL, 32'h1);
    wb_write(A_RS1, 32'h1234);
    check("t2_rs1_held", exec_rs1, 32'h10);
    wb_write(A_CTRL, 32'h1);
    repeat (4) @(negedge wb_clk_i);
    wb_read(A_STATUS, rd);  check("t2_status_err", rd, 32'h0000_0110);
    wb_write(A_STATUS, 32'h100);
    wb_read(A_STATUS, rd);  check("t2_status_clr", rd, 32'h0000_0010);
    wb_read(A_RES_LO, rd);  check("t2_res", rd, 32'h30);
    wb_read(A_STATUS, rd);  check("t2_one_entry", rd, 32'h0000_0002);

    // 3. full stall
    wb_write(A_RS2, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      wb_write(A_RS1, 32'(i));
      issue_and_wait();
    end
    wb_read(A_STATUS, rd);  check("t3_status_full_busy", rd, 32'h0000_0045);
    wb_read(A_RES_LO, rd);  check("t3_pop1", rd, 32'h1);
    wb_read(A_STATUS, rd);  check("t3_status_refill", rd, 32'h0000_0044);
    for (int i = 2; i <= 5; i++) begin
      wb_read(A_RES_LO, rd);
      check($sformatf("t3_pop%0d", i), rd, 32'(i));
    end
    wb_read(A_STATUS, rd);  check("t3_status_empty", rd, 32'h0000_0002);

    // 4. underflow
    wb_read(A_RES_LO, rd);  check("t4_underflow_data", rd, 32'h0);
    wb_read(A_STATUS, rd);  check("t4_status_uerr", rd, 32'h0000_0202);
    wb_write(A_RS1, 32'h7);
    wb_write(A_RS2, 32'h8);
    issue_and_wait();
    wb_read(A_RES_LO, rd);  check("t4_after_underflow", rd, 32'hF);
    wb_write(A_STATUS, 32'h200);
    wb_read(A_STATUS, rd);  check("t4_status_clr", rd, 32'h0000_0002);

    // 5. reset mid-operation
    wb_write(A_RS1, 32'hA);
    wb_write(A_RS2, 32'hB);
    issue_and_wait();
    issue_and_wait();
    wb_write(A_CTRL, 32'h1);
    @(negedge wb_clk_i);
    #2 wb_rst_ni = 0;
    #1;
    check("t5_ack", wbs_ack_o, 1'b0);
    check("t5_dat", wbs_dat_o, 32'h0);
    check("t5_insn", exec_instruction, 32'h0);
    check("t5_rs1", exec_rs1, 32'h0);
    check("t5_rs2", exec_rs2, 32'h0);
    check("t5_irq", irq_o, 1'b0);
    @(negedge wb_clk_i);
    #2 wb_rst_ni = 1;
    wb_read(A_STATUS, rd);  check("t5_status", rd, 32'h0000_0002);

    // 6. byte selects, then pointer wrap
    wb_xfer(1'b1, A_INSN, 32'hAABB_CCDD, 4'b0101, rd);
    wb_read(A_INSN, rd);    check("t6_insn_sel", rd, 32'h00BB_00DD);
    for (int i = 0; i < 10; i++) begin
      r1 = $urandom();
      r2 = $urandom();
      wb_write(A_RS1, r1);
      wb_write(A_RS2, r2);
      issue_and_wait();
      exp_q.push_back({1'b0, r1} + {1'b0, r2});
      if (i % 2 == 1) begin
        for (int k = 0; k < 2; k++) begin
          e = exp_q.pop_front();
          wb_read(A_RES_HI, rd);  check("t6_res_hi", rd, {31'd0, e[32]});
          wb_read(A_RES_LO, rd);  check("t6_res_lo", rd, e[31:0]);
        end
      end
    end

    // random traffic, including held strobes and unmapped addresses
    for (int c = 0; c < 2000; c++) begin
      @(negedge wb_clk_i);
      r1 = $urandom();
      wbs_cyc_i = ($urandom_range(0, 3) != 0);
      wbs_stb_i = ($urandom_range(0, 2) != 0);
      wbs_we_i  = 1'($urandom_range(0, 1));
      wbs_sel_i = 4'($urandom());
      wbs_adr_i = {r1[31:5], 3'($urandom_range(0, 7)), r1[1:0]};
      wbs_dat_i = $urandom();
    end
    @(negedge wb_clk_i);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    repeat (20) @(negedge wb_clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/masc_exec_sequencer.md
Name: masc_exec_sequencer

Overview:
- Wishbone-slave command front end that drives the `__masc__execute` operand interface ({instruction, rs1, rs2}) and collects its 33-bit result.
- It replaces direct logic-analyzer driving: the management SoC writes operands over Wishbone and issues a GO.
- The block holds operands stable for the execute latency, then samples the result into a small FIFO.
- The SoC pops results from that FIFO over Wishbone.

Parameters:
- EXEC_LAT, 2, cycles operands must be held before `exec_out` is valid (0..15).
- FIFO_DEPTH, 4, result FIFO entries (power of two, 2..8).

Ports:
- `wb_clk_i` input 1: single clock.
- `wb_rst_ni` input 1: asynchronous, active-low reset.
- `wbs_cyc_i` input 1: Wishbone cycle.
- `wbs_stb_i` input 1: Wishbone strobe.
- `wbs_we_i` input 1: write enable.
- `wbs_sel_i` input 4: byte selects.
- `wbs_adr_i` input 32: address; only [4:2] decoded.
- `wbs_dat_i` input 32: write data.
- `wbs_ack_o` output 1: single-cycle acknowledge.
- `wbs_dat_o` output 32: read data.
- `exec_instruction` output 32: to execute unit.
- `exec_rs1` output 32: to execute unit.
- `exec_rs2` output 32: to execute unit.
- `exec_out` input 33: result from execute unit.
- `irq_o` output 1: high while FIFO non-empty.

Behaviour:
- **Reset.** Every output, operand register, FIFO pointer, count, sticky flag and the FSM go to 0/IDLE asynchronously. Reset mid-operation discards the in-flight op and all FIFO contents.
- **Wishbone handshake.**
  - valid = cyc & stb.
  - `wbs_ack_o` pulses 1 cycle, registered, asserted the cycle after valid && !ack.
  - No back-to-back acks.
  - Side effects (write, GO, pop) occur on the acking edge only.
  - `wbs_dat_o` is valid with ack and 0 otherwise.
- **Register map (word address = `adr[4:2]`).**
  - 0 INSN (rw): byte-select honoured.
  - 1 RS1 (rw): byte-select honoured.
  - 2 RS2 (rw): byte-select honoured.
  - 3 CTRL:
    - Write with `dat[0]`=1 issues GO.
    - Read returns 0.
  - 4 STATUS:
    - Read: `[0]` busy, `[1]` empty, `[2]` full, `[7:4]` count, `[8]` issue_err, `[9]` underflow_err.
    - Write: 1 to bits 8/9 clears them.
  - 5 RES_LO (ro): returns FIFO head `[31:0]` and pops.
  - 6 RES_HI (ro, peek): returns `{31'b0, head[32]}`, no pop.
  - 7: reads 0, writes ignored.
  - Unmapped accesses are still acked.
- **Operand outputs.** `exec_*` are driven directly from the INSN/RS1/RS2 registers. They change only on Wishbone writes while IDLE.
- **FSM: IDLE, DRIVE, CAPTURE.**
  - IDLE:
    - GO accepted → DRIVE, with counter loaded with EXEC_LAT and busy=1.
    - Writes to INSN/RS1/RS2/GO while not IDLE are ignored and set issue_err.
  - DRIVE:
    - The counter decrements each cycle.
    - At 0 → CAPTURE.
  - CAPTURE:
    - If the FIFO is not full: push `exec_out`, go to IDLE, clear busy.
    - If full: stay in CAPTURE (stall, no data loss) until a pop frees a slot.
  - **Latency.** With space available, the push edge is exactly EXEC_LAT+2 cycles after the GO-accept edge. STATUS count reflects the push on the next read.
- **FIFO.**
  - Circular, with wrapping rd/wr pointers and a separate count of width clog2(FIFO_DEPTH)+1.
  - Simultaneous push and pop in one cycle: both take effect, count unchanged. This includes the case full + pop + push from stalled CAPTURE.
  - Pop when empty: returns 0, no pointer change, sets underflow_err.
- **Interrupt.** `irq_o` = !empty, registered from count.

Decomposition:
- Package `masc_seq_pkg`:
  - register word-address localparams (ADDR_INSN..ADDR_RES_HI);
  - STATUS bit-index constants;
  - FSM state enum typedef (2-bit).
- Sub-module `masc_result_fifo`:
  - parameterised width (33) and depth;
  - push/pop/full/empty/count;
  - same-cycle push+pop.
- All Wishbone decode and the FSM stay in the top.

Test Plan:
The bench execute model returns out = {carry, rs1+rs2}, pipelined EXEC_LAT.
1. **Basic issue.** Reset; write RS1=0xFFFF_FFFF, RS2=0x0000_0002, GO. Then:
   - push occurs at edge EXEC_LAT+2;
   - `irq_o`=1;
   - RES_HI reads 1, RES_LO reads 0x0000_0001;
   - STATUS then reads empty=1, count=0, `irq_o`=0.
2. **Busy protection.** GO, then immediately write RS1=0x1234 and GO again:
   - `exec_rs1` unchanged during DRIVE;
   - STATUS[8]=1;
   - only one FIFO entry;
   - writing STATUS=0x100 clears bit 8.
3. **Full stall.** Issue 5 ops with RS1=1..5, RS2=0 and no pops (FIFO_DEPTH=4):
   - STATUS shows full=1, busy=1, count=4;
   - pop returns 1;
   - the stalled op pushes on the same edge;
   - the following pops return 2, 3, 4, 5 in order.
4. **Underflow.** Read RES_LO on an empty FIFO: returns 0, STATUS[9]=1, pointers unchanged (next op's result reads correctly).
5. **Reset mid-op.** Assert `wb_rst_ni` low during DRIVE with 2 entries queued:
   - all outputs 0 immediately;
   - STATUS after release = 0x0000_0002 (empty only).
6. **Byte selects and wrap.** Write INSN=0xAABBCCDD with sel=4'b0101: INSN reads 0x00BB00DD. Run 10 ops with interleaved pops to exercise pointer wrap; results are in order.
